// File: rtl/mux_n_pipe_pkg.sv
// Shared sizing helpers for the pipelined N:1 select tree.
// Pure compile-time functions; no logic, no latency, no flow control.
// Imported by the interface, the tree stage and the top.
package mux_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int stages(input int levels, input int lps);
        return (levels + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Select-tree request/result bundle: en, in_valid, sel, data_in in; out, out_valid, out_sel back.
// Wires only, no latency.
// en is the only flow control; there is no ready signal.
interface mux_n_pipe_if #(
    parameter int WIDTH = 64,
    parameter int N     = 32
);
    import mux_pkg::*;

    localparam int SEL_W = clog2_min1(N);

    logic                    en;
    logic                    in_valid;
    logic [SEL_W-1:0]        sel;
    logic [N-1:0][WIDTH-1:0] data_in;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_sel;

    modport master (output en, in_valid, sel, data_in, input out, out_valid, out_sel);
    modport slave  (input en, in_valid, sel, data_in, output out, out_valid, out_sel);

endinterface

// File: rtl/mux_n_pipe_tree_stage.sv
// Combinational radix-2 reduction of IN_COUNT words over LEVELS levels, sel bits FIRST_LEVEL upward.
// Zero latency; purely combinational.
// No flow control; the caller registers the result.
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module mux_tree_stage #(
    parameter int WIDTH       = 64,
    parameter int IN_COUNT    = 4,
    parameter int LEVELS      = 2,
    parameter int SEL_W       = 5,
    parameter int FIRST_LEVEL = 0
) (
    input  logic [IN_COUNT-1:0][WIDTH-1:0]            din,
    input  logic [SEL_W-1:0]                          sel,
    output logic [(IN_COUNT >> LEVELS)-1:0][WIDTH-1:0] dout
);
    // Each stage only consumes its own slice of sel; the rest rides along for later stages.
    logic unused_sel;
    assign unused_sel = ^sel;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int CNT = IN_COUNT >> (k + 1);

        logic [2*CNT-1:0][WIDTH-1:0] src;
        logic [CNT-1:0][WIDTH-1:0]   res;

        if (k == 0) begin : g_src
            assign src = din;
        end else begin : g_src
            assign src = g_lvl[k-1].res;
        end

        for (genvar m = 0; m < CNT; m++) begin : g_node
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                mux2_cell u_cell (
                    .a (src[2*m][b]),
                    .b (src[2*m+1][b]),
                    .s (sel[FIRST_LEVEL+k]),
                    .y (res[m][b])
                );
            end
        end
    end

    assign dout = g_lvl[LEVELS-1].res;

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined N:1 WIDTH-bit select tree carrying valid and sel alongside the data.
// Latency ceil(LEVELS/LEVELS_PER_STAGE) enabled cycles, one result per enabled cycle.
// No backpressure; en = 0 freezes every stage and drops the inputs of that cycle.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH            = 64,
    parameter int N                = 32,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic        clk,
    input  logic        reset,
    mux_n_pipe_if.slave bus
);
    localparam int SEL_W  = clog2_min1(N);
    localparam int LEVELS = SEL_W;
    localparam int STAGES = stages(LEVELS, LEVELS_PER_STAGE);
    localparam int PADDED = 1 << LEVELS;

    typedef struct packed {
        logic             vld;
        logic [SEL_W-1:0] sel;
    } stage_ctl_t;

    // Leaves beyond N are tied to zero so out-of-range selects return 0.
    logic [PADDED-1:0][WIDTH-1:0] leaves;
    always_comb begin
        leaves = '0;
        for (int i = 0; i < N; i++) leaves[i] = bus.data_in[i];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST   = s * LEVELS_PER_STAGE;
        localparam int NLVL    = (LEVELS - FIRST < LEVELS_PER_STAGE) ? LEVELS - FIRST
                                                                     : LEVELS_PER_STAGE;
        localparam int IN_CNT  = PADDED >> FIRST;
        localparam int OUT_CNT = IN_CNT >> NLVL;

        logic [IN_CNT-1:0][WIDTH-1:0]  d_in;
        logic [OUT_CNT-1:0][WIDTH-1:0] d_nxt;
        logic [OUT_CNT-1:0][WIDTH-1:0] d_q;
        stage_ctl_t                    c_in;
        stage_ctl_t                    c_q;

        if (s == 0) begin : g_src
            assign d_in = leaves;
            assign c_in = {bus.in_valid, bus.sel};
        end else begin : g_src
            assign d_in = g_stage[s-1].d_q;
            assign c_in = g_stage[s-1].c_q;
        end

        mux_tree_stage #(
            .WIDTH       (WIDTH),
            .IN_COUNT    (IN_CNT),
            .LEVELS      (NLVL),
            .SEL_W       (SEL_W),
            .FIRST_LEVEL (FIRST)
        ) u_tree (
            .din  (d_in),
            .sel  (c_in.sel),
            .dout (d_nxt)
        );

        // Inner stages only drop their valid on reset; the output stage also clears out/out_sel.
        always_ff @(posedge clk) begin
            if (reset) begin
                c_q.vld <= 1'b0;
                if (s == STAGES - 1) begin
                    c_q.sel <= '0;
                    d_q     <= '0;
                end
            end else if (bus.en) begin
                c_q <= c_in;
                d_q <= d_nxt;
            end
        end
    end

    assign bus.out       = g_stage[STAGES-1].d_q[0];
    assign bus.out_valid = g_stage[STAGES-1].c_q.vld;
    assign bus.out_sel   = g_stage[STAGES-1].c_q.sel;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: default build against vector table plus queue model, small builds by hand.
module tb_mux_n_pipe;

    localparam logic [63:0] BASE     = 64'h1000_0000_0000_0000;
    localparam int          STAGES_A = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    mux_n_pipe_if #(.WIDTH(64), .N(32)) ifa ();
    mux_n_pipe_if #(.WIDTH(8),  .N(5))  ifb ();
    mux_n_pipe_if #(.WIDTH(16), .N(2))  ifc ();

    mux_n_pipe #(.WIDTH(64), .N(32), .LEVELS_PER_STAGE(2)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    mux_n_pipe #(.WIDTH(8),  .N(5),  .LEVELS_PER_STAGE(1)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));
    mux_n_pipe #(.WIDTH(16), .N(2),  .LEVELS_PER_STAGE(2)) dut_c (.clk(clk), .reset(rst_c), .bus(ifc));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a result is whatever was issue STAGES_A enabled cycles earlier.
    typedef struct {
        bit          known;
        bit          vld;
        logic [4:0]  sel;
        logic [63:0] dat;
    } item_t;

    item_t pipe_q[$];
    item_t mdl_out;

    typedef struct {
        bit          rst, en, vld;
        logic [4:0]  sel;
        bit          cv, ev, cd;
        logic [4:0]  esel;
        logic [63:0] eout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input bit en, input bit vld, input logic [4:0] sel,
                                input bit cv, input bit ev, input bit cd,
                                input logic [4:0] esel, input logic [63:0] eout);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.sel = sel;
        v.cv = cv; v.ev = ev; v.cd = cd; v.esel = esel; v.eout = eout;
        vecs.push_back(v);
    endfunction

    task automatic step_a(input bit rst, input bit en, input bit vld, input logic [4:0] sel);
        item_t it;
        rst_a = rst; ifa.en = en; ifa.in_valid = vld; ifa.sel = sel;
        @(posedge clk);
        if (rst) begin
            pipe_q.delete();
            for (int i = 0; i < STAGES_A - 1; i++)
                pipe_q.push_back('{known: 1'b0, vld: 1'b0, sel: 5'd0, dat: 64'd0});
            mdl_out = '{known: 1'b1, vld: 1'b0, sel: 5'd0, dat: 64'd0};
        end else if (en) begin
            it = '{known: 1'b1, vld: vld, sel: sel, dat: ifa.data_in[sel]};
            pipe_q.push_back(it);
            mdl_out = pipe_q.pop_front();
        end
        #1;
        check("a_model_vld", {63'd0, ifa.out_valid}, {63'd0, mdl_out.vld});
        if (mdl_out.known) begin
            check("a_model_out", ifa.out, mdl_out.dat);
            check("a_model_sel", {59'd0, ifa.out_sel}, {59'd0, mdl_out.sel});
        end
    endtask

    task automatic step_b(input bit rst, input bit en, input bit vld, input logic [2:0] sel);
        rst_b = rst; ifb.en = en; ifb.in_valid = vld; ifb.sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic step_c(input bit rst, input bit en, input bit vld, input logic sel);
        rst_c = rst; ifc.en = en; ifc.in_valid = vld; ifc.sel = sel;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] data_b [5];

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.en = 1'b1; ifa.in_valid = 1'b0; ifa.sel = '0;
        ifb.en = 1'b1; ifb.in_valid = 1'b0; ifb.sel = '0;
        ifc.en = 1'b1; ifc.in_valid = 1'b0; ifc.sel = '0;
        for (int i = 0; i < 32; i++) ifa.data_in[i] = BASE + 64'(i);
        data_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};
        for (int i = 0; i < 5; i++) ifb.data_in[i] = data_b[i];
        ifc.data_in[0] = 16'hBEEF;
        ifc.data_in[1] = 16'h1234;

        // ---------------- vector table for the default build ----------------
        add(1, 1, 0, 0, 1, 0, 1, 5'd0, 64'd0);
        for (int k = 0; k < 35; k++) begin
            bit e;
            e = (k >= 2) && (k - 2 < 32);
            add(0, 1, k < 32, (k < 32) ? 5'(k) : 5'd0, 1, e, e, 5'(k - 2), BASE + 64'(k - 2));
        end
        // stall of 4 cycles landing on the first result; stall-time inputs must vanish
        add(0, 1, 1, 5'd5, 1, 0, 0, 5'd0, 64'd0);
        add(0, 1, 1, 5'd6, 1, 0, 0, 5'd0, 64'd0);
        add(0, 1, 1, 5'd7, 1, 1, 1, 5'd5, BASE + 64'd5);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 5'd31, 1, 1, 1, 5'd5, BASE + 64'd5);
        add(0, 1, 0, 5'd0, 1, 1, 1, 5'd6, BASE + 64'd6);
        add(0, 1, 0, 5'd0, 1, 1, 1, 5'd7, BASE + 64'd7);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 5'd0, 1, 0, 0, 5'd0, 64'd0);
        // reset two cycles after the first of three issues
        add(0, 1, 1, 5'd9,  1, 0, 0, 5'd0, 64'd0);
        add(0, 1, 1, 5'd10, 1, 0, 0, 5'd0, 64'd0);
        add(1, 1, 1, 5'd11, 1, 0, 1, 5'd0, 64'd0);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 5'd0, 1, 0, 0, 5'd0, 64'd0);
        // bubbles 1,0,1,1,0
        add(0, 1, 1, 5'd1, 1, 0, 0, 5'd0, 64'd0);
        add(0, 1, 0, 5'd2, 1, 0, 0, 5'd0, 64'd0);
        add(0, 1, 1, 5'd3, 1, 1, 1, 5'd1, BASE + 64'd1);
        add(0, 1, 1, 5'd4, 1, 0, 0, 5'd0, 64'd0);
        add(0, 1, 0, 5'd5, 1, 1, 1, 5'd3, BASE + 64'd3);
        add(0, 1, 0, 5'd0, 1, 1, 1, 5'd4, BASE + 64'd4);
        add(0, 1, 0, 5'd0, 1, 0, 0, 5'd0, 64'd0);
        add(0, 1, 0, 5'd0, 1, 0, 0, 5'd0, 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].sel);
            if (vecs[i].cv)
                check($sformatf("tbl%0d_vld", i), {63'd0, ifa.out_valid}, {63'd0, vecs[i].ev});
            if (vecs[i].cd) begin
                check($sformatf("tbl%0d_out", i), ifa.out, vecs[i].eout);
                check($sformatf("tbl%0d_sel", i), {59'd0, ifa.out_sel}, {59'd0, vecs[i].esel});
            end
        end

        // ---------------- randomized traffic against the queue model ----------------
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 32; i++) ifa.data_in[i] = {$urandom, $urandom};
            step_a($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // ---------------- N=5, WIDTH=8, one level per stage: padded selects ----------------
        step_b(1, 1, 0, 3'd0);
        check("b_rst_vld", {63'd0, ifb.out_valid}, 64'd0);
        check("b_rst_out", {56'd0, ifb.out}, 64'd0);
        for (int k = 0; k < 11; k++) begin
            step_b(0, 1, k < 8, (k < 8) ? 3'(k) : 3'd0);
            if (k >= 2 && k - 2 < 8) begin
                check($sformatf("b%0d_vld", k), {63'd0, ifb.out_valid}, 64'd1);
                check($sformatf("b%0d_out", k), {56'd0, ifb.out},
                      (k - 2 < 5) ? {56'd0, data_b[k-2]} : 64'd0);
                check($sformatf("b%0d_sel", k), {61'd0, ifb.out_sel}, 64'(k - 2));
            end else begin
                check($sformatf("b%0d_vld", k), {63'd0, ifb.out_valid}, 64'd0);
            end
        end

        // ---------------- N=2, WIDTH=16: single stage, latency 1 ----------------
        step_c(1, 1, 1, 1'b1);
        check("c_rst_vld", {63'd0, ifc.out_valid}, 64'd0);
        check("c_rst_out", {48'd0, ifc.out}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            step_c(0, 1, 1, 1'(k));
            check($sformatf("c%0d_vld", k), {63'd0, ifc.out_valid}, 64'd1);
            check($sformatf("c%0d_out", k), {48'd0, ifc.out}, (k % 2 == 1) ? 64'h1234 : 64'hBEEF);
            check($sformatf("c%0d_sel", k), {63'd0, ifc.out_sel}, 64'(k % 2));
        end
        step_c(0, 1, 0, 1'b0);
        check("c_bubble_vld", {63'd0, ifc.out_valid}, 64'd0);
        step_c(0, 0, 1, 1'b1);
        check("c_stall_vld", {63'd0, ifc.out_valid}, 64'd0);
        step_c(0, 1, 1, 1'b1);
        check("c_resume_vld", {63'd0, ifc.out_valid}, 64'd1);
        check("c_resume_out", {48'd0, ifc.out}, 64'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
